handshake_arbiter: RTL and testbench

- Shares one four-phase sync/ack slave datapath among N four-phase masters.
- Each master raises sync with a request word. The arbiter grants one master round-robin, forwards the word to the slave, and runs a full slave handshake.
- It then returns the slave result to the granted master and completes that master's handshake.
- Sits between processing front-ends (PUF/ring-oscillator measurement masters) and a single shared compute slave.

---
 rtl/handshake_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_handshake_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_arbiter.sv
// handshake_arbiter: shares one four-phase sync/ack slave among N four-phase masters,
// granting round-robin and relaying the request word and slave result.
//
// Ports:
//   clock       system clock, all logic on posedge
//   reset_n     synchronous active-low reset
//   m_sync      per-master request (four-phase sync)
//   m_ack       per-master acknowledge, one-hot or zero
//   m_data_in   master request words, master i at [i*WIDTH +: WIDTH]
//   m_data_out  latched slave result, valid while m_ack[i]=1
//   s_sync      sync to the shared slave
//   s_ack       ack from the shared slave
//   s_data_out  request word to the slave
//   s_data_in   result from the slave
//   grant       index of the current/last granted master
//   busy        high in any state other than IDLE
//   timeout     one-cycle pulse on watchdog abort
//
// Optional feature: define HS_ARB_TIMEOUT_EN to enable the slave-ack watchdog.
// Without it FWD waits indefinitely and timeout is tied low.
module handshake_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N-1:0]         m_sync,
  output logic [N-1:0]         m_ack,
  input  logic [N*WIDTH-1:0]   m_data_in,
  output logic [WIDTH-1:0]     m_data_out,
  output logic                 s_sync,
  input  logic                 s_ack,
  output logic [WIDTH-1:0]     s_data_out,
  input  logic [WIDTH-1:0]     s_data_in,
  output logic [$clog2(N)-1:0] grant,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned GW = $clog2(N);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FWD   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Elaboration-time parameter sanity.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("handshake_arbiter: N must be in 2..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("handshake_arbiter: TIMEOUT must be at least 2");
  end

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [N-1:0]     m_ack_nxt;
  logic [WIDTH-1:0] m_data_out_nxt;
  logic             s_sync_nxt;
  logic [WIDTH-1:0] s_data_out_nxt;
  logic [GW-1:0]    grant_nxt;

  logic             req_found_c;
  logic [GW-1:0]    req_idx_c;
  logic [WIDTH-1:0] req_word_c;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd;
  logic [WDW-1:0] wd_nxt;
  logic           timeout_nxt;
`endif

  // Round-robin pick: first requester after the last grant, wrapping modulo N.
  always_comb begin
    req_found_c = 1'b0;
    req_idx_c   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      if (!req_found_c && m_sync[GW'((32'(grant) + off) % N)]) begin
        req_found_c = 1'b1;
        req_idx_c   = GW'((32'(grant) + off) % N);
      end
    end
  end

  // Request word of the selected master.
  always_comb begin
    req_word_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_idx_c == GW'(i)) begin
        req_word_c = m_data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    m_ack_nxt      = m_ack;
    m_data_out_nxt = m_data_out;
    s_sync_nxt     = s_sync;
    s_data_out_nxt = s_data_out;
    grant_nxt      = grant;
`ifdef HS_ARB_TIMEOUT_EN
    wd_nxt         = wd;
    timeout_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req_found_c) begin
          grant_nxt      = req_idx_c;
          s_data_out_nxt = req_word_c;
          s_sync_nxt     = 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
          wd_nxt         = '0;
`endif
          state_nxt      = FWD;
        end
      end
      FWD: begin
        // A stale s_ack still high on entry is accepted as the answer.
        if (s_ack) begin
          m_data_out_nxt = s_data_in;
          s_sync_nxt     = 1'b0;
          state_nxt      = DRAIN;
        end
`ifdef HS_ARB_TIMEOUT_EN
        else if (wd == WDW'(TIMEOUT - 1)) begin
          m_data_out_nxt = '1;
          s_sync_nxt     = 1'b0;
          timeout_nxt    = 1'b1;
          state_nxt      = DRAIN;
        end else begin
          wd_nxt = wd + WDW'(1);
        end
`endif
      end
      DRAIN: begin
        if (!s_ack) begin
          m_ack_nxt = N'(1) << grant;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!m_sync[grant]) begin
          m_ack_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      m_ack      <= '0;
      m_data_out <= '0;
      s_sync     <= 1'b0;
      s_data_out <= '0;
      grant      <= GW'(N - 1);
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      m_ack      <= m_ack_nxt;
      m_data_out <= m_data_out_nxt;
      s_sync     <= s_sync_nxt;
      s_data_out <= s_data_out_nxt;
      grant      <= grant_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  // Watchdog counter and abort pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      wd      <= wd_nxt;
      timeout <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_handshake_arbiter.sv
// tb_handshake_arbiter: self-checking bench for handshake_arbiter (N=4, WIDTH=32).
// Bench-side master and slave models run on the falling edge; a scoreboard of
// expected {grant, word, result} entries is checked at s_sync rise and m_ack rise.
`timescale 1ns/1ps
module tb_handshake_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned GW    = $clog2(N);
`ifdef HS_ARB_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 16;
`else
  localparam int unsigned TIMEOUT = 1024;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         m_sync;
  logic [N-1:0]         m_ack;
  logic [N*WIDTH-1:0]   m_data_in;
  logic [WIDTH-1:0]     m_data_out;
  logic                 s_sync;
  logic                 s_ack;
  logic [WIDTH-1:0]     s_data_out;
  logic [WIDTH-1:0]     s_data_in;
  logic [GW-1:0]        grant;
  logic                 busy;
  logic                 timeout;

  handshake_arbiter #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .m_sync     (m_sync),
    .m_ack      (m_ack),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .s_sync     (s_sync),
    .s_ack      (s_ack),
    .s_data_out (s_data_out),
    .s_data_in  (s_data_in),
    .grant      (grant),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [GW-1:0]    grant;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] result;
  } sb_t;

  typedef struct {
    int unsigned      master;
    logic [WIDTH-1:0] word;
    int unsigned      lat;
    int unsigned      rel;
    logic [GW-1:0]    exp_grant;
    logic [WIDTH-1:0] exp_result;
    logic [N-1:0]     exp_ack;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[4];

  int          checks   = 0;
  int          failures = 0;

  int unsigned want[N];
  logic [31:0] mword[N];
  int unsigned ack_seen[N];
  int unsigned slave_lat  = 1;
  int unsigned slave_rel  = 0;
  int unsigned lat_cnt    = 0;
  int unsigned rel_cnt    = 0;
  bit          slave_dead = 1'b0;
  logic        prev_s_sync = 1'b0;
  logic [N-1:0] prev_m_ack = '0;
  int unsigned to_pulses  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [GW-1:0] g, input logic [31:0] w, input logic [31:0] r);
    sb_t e;
    e.grant  = g;
    e.word   = w;
    e.result = r;
    sb_q.push_back(e);
  endtask

  function automatic bit any_want();
    for (int i = 0; i < N; i++) begin
      if (want[i] != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor, slave model and master models; runs once per falling edge.
  task automatic model_update();
    sb_t e;
    if (timeout === 1'b1) to_pulses++;
    if (s_sync === 1'b1 && prev_s_sync !== 1'b1) begin
      chk("slave_released_before_sync", 32'(s_ack), 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: actual grant=%0d required=no transaction", grant);
      end else begin
        chk("grant_at_fwd", 32'(grant), 32'(sb_q[0].grant));
        chk("s_data_out", s_data_out, sb_q[0].word);
      end
    end
    if (m_ack !== '0 && prev_m_ack === '0) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: actual m_ack=%b required=none", m_ack);
      end else begin
        e = sb_q.pop_front();
        chk("m_ack_onehot", 32'(m_ack), 32'(N'(1) << e.grant));
        chk("m_data_out", m_data_out, e.result);
        chk("grant_at_ack", 32'(grant), 32'(e.grant));
`ifndef HS_ARB_TIMEOUT_EN
        chk("timeout_tied", 32'(timeout), 32'd0);
`endif
      end
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) ack_seen[i]++;
      end
    end
    prev_s_sync = s_sync;
    prev_m_ack  = m_ack;

    if (!s_ack) begin
      rel_cnt = 0;
      if (s_sync === 1'b1 && !slave_dead) begin
        lat_cnt++;
        if (lat_cnt >= slave_lat) begin
          s_ack     = 1'b1;
          s_data_in = s_data_out + 32'd1;
          lat_cnt   = 0;
        end
      end else begin
        lat_cnt = 0;
      end
    end else if (s_sync !== 1'b1) begin
      rel_cnt++;
      if (rel_cnt > slave_rel) s_ack = 1'b0;
    end

    for (int i = 0; i < N; i++) begin
      if (m_sync[i] && m_ack[i] === 1'b1) begin
        m_sync[i] = 1'b0;
        if (want[i] != 0) want[i]--;
        mword[i] = mword[i] + 32'h10;
      end else if (!m_sync[i] && m_ack[i] === 1'b0 && want[i] != 0) begin
        m_sync[i] = 1'b1;
        m_data_in[i*WIDTH +: WIDTH] = mword[i];
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    model_update();
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    forever begin
      tick();
      n++;
      if (!busy && m_ack == '0 && !any_want()) break;
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL %s_budget: actual=%0d cycles required<%0d", name, n, budget);
        break;
      end
    end
    chk({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned n;
    int unsigned hi;
    int unsigned gap;
    int unsigned m;
    logic        ps;

    vecs[0] = '{master: 2, word: 32'h0000_00A5, lat: 3, rel: 0,
                exp_grant: 2'd2, exp_result: 32'h0000_00A6, exp_ack: 4'b0100};
    vecs[1] = '{master: 0, word: 32'h1234_5678, lat: 1, rel: 0,
                exp_grant: 2'd0, exp_result: 32'h1234_5679, exp_ack: 4'b0001};
    vecs[2] = '{master: 3, word: 32'hFFFF_FFFF, lat: 5, rel: 2,
                exp_grant: 2'd3, exp_result: 32'h0000_0000, exp_ack: 4'b1000};
    vecs[3] = '{master: 1, word: 32'h7FFF_FFFF, lat: 1, rel: 3,
                exp_grant: 2'd1, exp_result: 32'h8000_0000, exp_ack: 4'b0010};

    reset_n   = 1'b0;
    m_sync    = '0;
    m_data_in = '0;
    s_ack     = 1'b0;
    s_data_in = '0;
    for (int i = 0; i < N; i++) begin
      want[i]     = 0;
      mword[i]    = '0;
      ack_seen[i] = 0;
    end

    // Reset state.
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_ack", 32'(m_ack), 32'd0);
    chk("rst_s_sync", 32'(s_sync), 32'd0);
    chk("rst_s_data_out", s_data_out, 32'd0);
    chk("rst_m_data_out", m_data_out, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset_n = 1'b1;
    tick();

    // Round-robin fairness: all four masters request twice back to back.
    slave_lat = 1;
    slave_rel = 0;
    for (int i = 0; i < N; i++) begin
      mword[i]    = 32'(i + 1) << 28;
      want[i]     = 2;
      ack_seen[i] = 0;
    end
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < N; i++) begin
        push_exp(GW'(i), (32'(i + 1) << 28) + 32'(16 * t), (32'(i + 1) << 28) + 32'(16 * t) + 32'd1);
      end
    end
    wait_done("fairness", 400);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("fair_acks_m%0d", i), 32'(ack_seen[i]), 32'd2);
    end

    // Table of single-master transactions.
    for (int v = 0; v < 4; v++) begin
      m         = vecs[v].master;
      slave_lat = vecs[v].lat;
      slave_rel = vecs[v].rel;
      mword[m]  = vecs[v].word;
      want[m]   = 1;
      push_exp(vecs[v].exp_grant, vecs[v].word, vecs[v].exp_result);
      tick();
      tick();
      chk($sformatf("v%0d_req_latency", v), 32'(s_sync), 32'd1);
      n = 0;
      while (m_ack == '0 && n < 50) begin
        tick();
        n++;
      end
      chk($sformatf("v%0d_ack", v), 32'(m_ack), 32'(vecs[v].exp_ack));
      chk($sformatf("v%0d_result", v), m_data_out, vecs[v].exp_result);
      chk($sformatf("v%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
      chk($sformatf("v%0d_busy_held", v), 32'(busy), 32'd1);
      tick();
      chk($sformatf("v%0d_busy_fall", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_ack_fall", v), 32'(m_ack), 32'd0);
      wait_done($sformatf("vec%0d", v), 100);
    end

    // Blocked requester: master 1 asks while master 3 is in FWD, then changes its word.
    slave_lat = 6;
    slave_rel = 0;
    mword[3]  = 32'h3333_0001;
    want[3]   = 1;
    push_exp(2'd3, 32'h3333_0001, 32'h3333_0002);
    tick();
    tick();
    tick();
    chk("m3_in_fwd", 32'(s_sync), 32'd1);
    mword[1] = 32'h1111_0001;
    want[1]  = 1;
    push_exp(2'd1, 32'h1111_0001, 32'h1111_0002);
    n = 0;
    tick();
    while (!(s_sync === 1'b1 && grant == 2'd1) && n < 100) begin
      tick();
      n++;
    end
    chk("blocked_grant", 32'(grant), 32'd1);
    m_data_in[1*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("s_data_latched", s_data_out, 32'h1111_0001);
    wait_done("blocked", 100);

    // Slow slave release: m_ack must wait for s_ack to fall.
    slave_lat = 2;
    slave_rel = 5;
    mword[0]  = 32'h0000_5A5A;
    want[0]   = 1;
    push_exp(2'd0, 32'h0000_5A5A, 32'h0000_5A5B);
    n = 0;
    while (n < 100) begin
      ps = s_sync;
      tick();
      n++;
      if (ps && !s_sync) break;
    end
    gap = 0;
    while (m_ack == '0 && gap < 50) begin
      tick();
      gap++;
    end
    chk("release_gap", 32'(gap), 32'd6);
    wait_done("slow_release", 100);

    // Reset during DRAIN, then master 0 and the aborted master 2 both request.
    slave_lat = 2;
    slave_rel = 0;
    mword[2]  = 32'h2222_0077;
    want[2]   = 1;
    push_exp(2'd2, 32'h2222_0077, 32'h2222_0078);
    n = 0;
    while (n < 100) begin
      ps = s_sync;
      tick();
      n++;
      if (ps && !s_sync) break;
    end
    chk("drain_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_m_ack", 32'(m_ack), 32'd0);
    chk("mid_rst_s_sync", 32'(s_sync), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd3);
    sb_q.delete();
    reset_n  = 1'b1;
    mword[0] = 32'h0000_0F0F;
    want[0]  = 1;
    m_sync[0] = 1'b1;
    m_data_in[0 +: WIDTH] = 32'h0000_0F0F;
    push_exp(2'd0, 32'h0000_0F0F, 32'h0000_0F10);
    push_exp(2'd2, 32'h2222_0077, 32'h2222_0078);
    tick();
    chk("post_rst_grant", 32'(grant), 32'd0);
    chk("post_rst_s_sync", 32'(s_sync), 32'd1);
    wait_done("post_reset", 200);

`ifdef HS_ARB_TIMEOUT_EN
    // Watchdog: slave never answers.
    slave_dead = 1'b1;
    mword[1]   = 32'h1357_9BDF;
    want[1]    = 1;
    push_exp(2'd1, 32'h1357_9BDF, 32'hFFFF_FFFF);
    to_pulses = 0;
    hi = 0;
    n  = 0;
    tick();
    while (n < 200) begin
      tick();
      n++;
      if (s_sync) hi++;
      else if (hi > 0) break;
    end
    chk("fwd_cycles", 32'(hi), 32'd16);
    chk("timeout_at_abort", 32'(timeout), 32'd1);
    slave_dead = 1'b0;
    wait_done("watchdog", 100);
    chk("timeout_pulses", 32'(to_pulses), 32'd1);
`else
    chk("no_timeout_pulses", 32'(to_pulses), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
